// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: N-channel LED PWM engine with static, colour-cycle and breathing modes.
// Build macro RGB_PWM_GAMMA_EN enables squared (perceptual) duty correction; default is linear.
module rgb_pwm_fader #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned PRESCALE    = 94,
  parameter int unsigned HOLD_FRAMES = 500,
  parameter int unsigned FADE_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [NUM_CH*PWM_BITS-1:0] level_in,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic                       frame_stb
);

  localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FRM_MAX = (HOLD_FRAMES > FADE_FRAMES) ? HOLD_FRAMES : FADE_FRAMES;
  localparam int unsigned FRM_W   = (FRM_MAX > 1) ? $clog2(FRM_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PROD_W  = 2 * PWM_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STATIC,
    ST_CYCLE,
    ST_RAMP_UP,
    ST_RAMP_DOWN
  } state_t;

  state_t               state_q, state_n, target;
  logic [PRE_W-1:0]     presc_q;
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic [PWM_BITS-1:0]  env_q, env_n;
  logic [IDX_W-1:0]     cyc_q, cyc_n;
  logic [FRM_W-1:0]     frm_q, frm_n;
  logic                 tick;
  logic                 wrap;
  logic                 switch_mode;
  logic [NUM_CH-1:0]    cmp;

  assign tick = (presc_q == PRE_W'(PRESCALE - 1));
  assign wrap = tick && (pwm_cnt_q == CNT_MAX);

  // Tick prescaler, PWM counter and frame strobe; all held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      frame_stb <= 1'b0;
    end else begin
      presc_q   <= tick ? '0 : presc_q + PRE_W'(1);
      if (tick) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      frame_stb <= wrap;
    end
  end

  always_comb begin
    case (mode)
      2'd1:    target = ST_CYCLE;
      2'd2:    target = ST_RAMP_UP;
      default: target = ST_STATIC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      env_q   <= '0;
      cyc_q   <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_n;
      env_q   <= env_n;
      cyc_q   <= cyc_n;
      frm_q   <= frm_n;
    end
  end

  // Mode and envelope sequencing; everything advances only on the frame-wrap tick
  always_comb begin
    state_n     = state_q;
    env_n       = env_q;
    cyc_n       = cyc_q;
    frm_n       = frm_q;
    switch_mode = 1'b0;
    if (!enable) begin
      state_n = ST_OFF;
      env_n   = '0;
      cyc_n   = '0;
      frm_n   = '0;
    end else if (wrap) begin
      case (state_q)
        ST_CYCLE: begin
          if (target == ST_CYCLE) begin
            if (frm_q == FRM_W'(HOLD_FRAMES - 1)) begin
              frm_n = '0;
              cyc_n = (cyc_q == IDX_W'(NUM_CH - 1)) ? '0 : cyc_q + IDX_W'(1);
            end else begin
              frm_n = frm_q + FRM_W'(1);
            end
          end else begin
            switch_mode = 1'b1;
          end
        end
        ST_RAMP_UP, ST_RAMP_DOWN: begin
          if (target == ST_RAMP_UP) begin
            if (frm_q == FRM_W'(FADE_FRAMES - 1)) begin
              frm_n = '0;
              if (state_q == ST_RAMP_UP) begin
                env_n = env_q + PWM_BITS'(1);
                if (env_n == CNT_MAX) state_n = ST_RAMP_DOWN;
              end else begin
                env_n = env_q - PWM_BITS'(1);
                if (env_n == '0) state_n = ST_RAMP_UP;
              end
            end else begin
              frm_n = frm_q + FRM_W'(1);
            end
          end else begin
            switch_mode = 1'b1;
          end
        end
        default: begin
          if (target != state_q) switch_mode = 1'b1;
        end
      endcase
      if (switch_mode) begin
        state_n = target;
        frm_n   = '0;
        if (target == ST_CYCLE)   cyc_n = '0;
        if (target == ST_RAMP_UP) env_n = '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] lin;
    logic [PWM_BITS-1:0] duty_n;
    logic [PWM_BITS-1:0] duty_q;

    assign lvl = level_in[g*PWM_BITS +: PWM_BITS];

    // Duty for the upcoming frame, derived from the post-boundary state
    always_comb begin
      lin = '0;
      case (state_n)
        ST_STATIC: lin = lvl;
        ST_CYCLE:  lin = (cyc_n == IDX_W'(g)) ? lvl : '0;
        ST_RAMP_UP, ST_RAMP_DOWN:
          lin = PWM_BITS'((PROD_W'(lvl) * PROD_W'(env_n)) >> PWM_BITS);
        default:   lin = '0;
      endcase
    end

`ifdef RGB_PWM_GAMMA_EN
    assign duty_n = PWM_BITS'((PROD_W'(lin) * PROD_W'(lin)) >> PWM_BITS);
`else
    assign duty_n = lin;
`endif

    always_ff @(posedge clk) begin
      if (rst || !enable) duty_q <= '0;
      else if (wrap)      duty_q <= duty_n;
    end

    assign cmp[g] = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) pwm_out <= '0;
    else                pwm_out <= cmp;
  end

endmodule
